// File: rtl/rf_arb_pkg.sv
// rf_arb_pkg: shared types and constants for the register-file port arbiter.
// The capture record holds one requester's access fields for the duration of
// its transaction.
package rf_arb_pkg;

   localparam int NUM_REQ = 2;
   localparam int RF_AW   = 4;
   localparam int RF_DW   = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } arb_state_t;

   typedef logic req_id_t;

   typedef struct packed {
      logic [RF_AW-1:0] ra;
      logic [RF_AW-1:0] rb;
      logic [RF_AW-1:0] rd;
      logic             we;
      logic [RF_DW-1:0] wdata;
      logic             lock;
   } cap_rec_t;

   // Turn a requester id into its one-hot strobe position.
   function automatic logic [NUM_REQ-1:0] id_onehot(input req_id_t id);
      return id ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/rf_port_arbiter_rr_pick.sv
// rr_pick: combinational two-way round-robin picker. A lone requester wins
// outright; when both request, the pointer decides.
module rr_pick
   import rf_arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  req_id_t            rr_ptr,
   output req_id_t            winner,
   output logic               any
);

   // Winner selection: contention is settled by the round-robin pointer.
   always_comb begin
      any    = |req;
      winner = 1'b0;
      if (req == 2'b11) begin
         winner = rr_ptr;
      end else if (req[1]) begin
         winner = 1'b1;
      end
   end

endmodule

// File: rtl/rf_port_arbiter.sv
// rf_port_arbiter: shares the 16x8 register file between the core control FSM
// (requester 0) and the debug/loader port (requester 1). Each grant is an
// IDLE/ACCESS/RESP transaction; a locked owner may chain accesses back to
// back up to LOCK_MAX grants before rotation is forced.
// Optional build macro RF_ARB_R0_ZERO_EN: r0 reads as zero and is never written.
module rf_port_arbiter
   import rf_arb_pkg::*;
#(
   parameter int DW       = RF_DW,
   parameter int AW       = RF_AW,
   parameter int LOCK_MAX = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [1:0]    req,
   input  logic [1:0]    lock,
   input  logic [1:0]    we,
   input  logic [AW-1:0] ra0,
   input  logic [AW-1:0] rb0,
   input  logic [AW-1:0] rd0,
   input  logic [AW-1:0] ra1,
   input  logic [AW-1:0] rb1,
   input  logic [AW-1:0] rd1,
   input  logic [DW-1:0] wdata0,
   input  logic [DW-1:0] wdata1,
   output logic [1:0]    gnt,
   output logic [1:0]    rvalid,
   output logic [DW-1:0] rdata_a,
   output logic [DW-1:0] rdata_b,
   output logic [AW-1:0] rf_ra,
   output logic [AW-1:0] rf_rb,
   output logic [AW-1:0] rf_rd,
   output logic          rf_we,
   output logic [DW-1:0] rf_wdata,
   input  logic [DW-1:0] rf_outa,
   input  logic [DW-1:0] rf_outb
);

   // Last locked grant index: the owner may chain while its count is below this.
   localparam logic [3:0] LOCK_LAST = 4'(LOCK_MAX - 1);

   arb_state_t    state_q, state_d;
   req_id_t       owner_q, owner_d;
   req_id_t       rr_ptr_q, rr_ptr_d;
   logic [3:0]    lock_cnt_q, lock_cnt_d;
   cap_rec_t      cap_q, cap_d;
   logic [DW-1:0] rdata_a_q, rdata_b_q;

   cap_rec_t      rec0, rec1;
   req_id_t       arb_ptr;
   req_id_t       pick_win;
   logic          pick_any;
   logic [DW-1:0] rd_a_val, rd_b_val;
   logic          wr_allow;

   assign rec0 = '{ra: ra0, rb: rb0, rd: rd0, we: we[0], wdata: wdata0, lock: lock[0]};
   assign rec1 = '{ra: ra1, rb: rb1, rd: rd1, we: we[1], wdata: wdata1, lock: lock[1]};

   // A fresh arbitration out of RESP already sees the rotated pointer.
   assign arb_ptr = (state_q == RESP) ? ~owner_q : rr_ptr_q;

   rr_pick u_pick (
      .req    (req),
      .rr_ptr (arb_ptr),
      .winner (pick_win),
      .any    (pick_any)
   );

`ifdef RF_ARB_R0_ZERO_EN
   assign rd_a_val = (cap_q.ra == '0) ? '0 : rf_outa;
   assign rd_b_val = (cap_q.rb == '0) ? '0 : rf_outb;
   assign wr_allow = (cap_q.rd != '0);
`else
   assign rd_a_val = rf_outa;
   assign rd_b_val = rf_outb;
   assign wr_allow = 1'b1;
`endif

   // Next-state: arbitrate in IDLE/RESP, chain locked owners, rotate otherwise.
   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      rr_ptr_d   = rr_ptr_q;
      lock_cnt_d = lock_cnt_q;
      cap_d      = cap_q;
      unique case (state_q)
         IDLE: begin
            if (pick_any) begin
               state_d = ACCESS;
               owner_d = pick_win;
               cap_d   = pick_win ? rec1 : rec0;
            end
         end
         ACCESS: begin
            state_d = RESP;
         end
         RESP: begin
            if (cap_q.lock && (lock_cnt_q < LOCK_LAST) && req[owner_q]) begin
               lock_cnt_d = lock_cnt_q + 4'd1;
               state_d    = ACCESS;
               cap_d      = owner_q ? rec1 : rec0;
            end else begin
               lock_cnt_d = '0;
               rr_ptr_d   = ~owner_q;
               if (pick_any) begin
                  state_d = ACCESS;
                  owner_d = pick_win;
                  cap_d   = pick_win ? rec1 : rec0;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and capture registers; reset drops any in-flight access.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         owner_q    <= 1'b0;
         rr_ptr_q   <= 1'b0;
         lock_cnt_q <= '0;
         cap_q      <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         rr_ptr_q   <= rr_ptr_d;
         lock_cnt_q <= lock_cnt_d;
         cap_q      <= cap_d;
      end
   end

   // Read data is sampled during ACCESS, before that access's write lands.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rdata_a_q <= '0;
         rdata_b_q <= '0;
      end else if (state_q == ACCESS) begin
         rdata_a_q <= rd_a_val;
         rdata_b_q <= rd_b_val;
      end
   end

   assign gnt      = (state_q == ACCESS) ? id_onehot(owner_q) : 2'b00;
   assign rvalid   = (state_q == RESP)   ? id_onehot(owner_q) : 2'b00;
   assign rdata_a  = rdata_a_q;
   assign rdata_b  = rdata_b_q;
   assign rf_ra    = cap_q.ra;
   assign rf_rb    = cap_q.rb;
   assign rf_rd    = cap_q.rd;
   assign rf_wdata = cap_q.wdata;
   assign rf_we    = (state_q == ACCESS) && cap_q.we && wr_allow;

endmodule

// File: tb/tb_rf_port_arbiter.sv
// tb_rf_port_arbiter: directed scenarios followed by random traffic, all
// checked against a transaction-level model of the arbitration rules and a
// shadow copy of the register file.
module tb_rf_port_arbiter;

   localparam int DW       = 8;
   localparam int AW       = 4;
   localparam int LOCK_MAX = 4;
   localparam int NCYC     = 4096;

   logic          clk = 1'b0;
   logic          reset;
   logic          mem_load;
   logic [1:0]    req, lock, we;
   logic [AW-1:0] ra0, rb0, rd0, ra1, rb1, rd1;
   logic [DW-1:0] wdata0, wdata1;
   logic [1:0]    gnt, rvalid;
   logic [DW-1:0] rdata_a, rdata_b, rf_wdata, rf_outa, rf_outb;
   logic [AW-1:0] rf_ra, rf_rb, rf_rd;
   logic          rf_we;
   logic [DW-1:0] rf_mem [16];

   rf_port_arbiter #(.DW(DW), .AW(AW), .LOCK_MAX(LOCK_MAX)) dut (
      .clk(clk), .reset(reset), .req(req), .lock(lock), .we(we),
      .ra0(ra0), .rb0(rb0), .rd0(rd0), .ra1(ra1), .rb1(rb1), .rd1(rd1),
      .wdata0(wdata0), .wdata1(wdata1), .gnt(gnt), .rvalid(rvalid),
      .rdata_a(rdata_a), .rdata_b(rdata_b), .rf_ra(rf_ra), .rf_rb(rf_rb),
      .rf_rd(rf_rd), .rf_we(rf_we), .rf_wdata(rf_wdata),
      .rf_outa(rf_outa), .rf_outb(rf_outb)
   );

   always #5 clk = ~clk;

   // Register file: combinational reads, write on the clock edge.
   assign rf_outa = rf_mem[rf_ra];
   assign rf_outb = rf_mem[rf_rb];
   always @(posedge clk) begin
      if (mem_load) begin
         for (int i = 0; i < 16; i++) rf_mem[i] <= 8'(i * 17);
      end else if (rf_we) begin
         rf_mem[rf_rd] <= rf_wdata;
      end
   end

   // Reference model state: per-cycle expectations plus arbitration bookkeeping.
   logic [DW-1:0] shadow [16];
   logic [1:0]    e_gnt [NCYC];
   logic [1:0]    e_rv  [NCYC];
   logic          e_we  [NCYC];
   logic [DW-1:0] e_ra  [NCYC];
   logic [DW-1:0] e_rb  [NCYC];
   logic          w_en  [NCYC];
   logic [AW-1:0] w_addr[NCYC];
   logic [DW-1:0] w_data[NCYC];
   int            cyc, next_dec, streak;
   logic          at_resp, fav, last_owner, last_lock;
   logic [1:0]    pend;
   bit            auto_drv;
   int            n_cmp, n_err;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic model_clear(input int from);
      for (int i = from; i < NCYC; i++) begin
         e_gnt[i] = '0; e_rv[i] = '0; e_we[i] = 1'b0; e_ra[i] = '0; e_rb[i] = '0;
         w_en[i] = 1'b0; w_addr[i] = '0; w_data[i] = '0;
      end
   endtask

   task automatic check_cycle();
      if (w_en[cyc]) shadow[w_addr[cyc]] = w_data[cyc];
      chk("gnt", 32'(gnt), 32'(e_gnt[cyc]));
      chk("rvalid", 32'(rvalid), 32'(e_rv[cyc]));
      chk("rf_we", 32'(rf_we), 32'(e_we[cyc]));
      if (e_rv[cyc] != 2'b00) begin
         chk("rdata_a", 32'(rdata_a), 32'(e_ra[cyc]));
         chk("rdata_b", 32'(rdata_b), 32'(e_rb[cyc]));
      end
   endtask

   // Arbitration decision for the request sampled at the end of this cycle.
   task automatic decide();
      bit            cont;
      logic          win;
      logic [AW-1:0] a, b, d;
      logic          w;
      logic [DW-1:0] wd;
      if (cyc != next_dec) return;
      cont = at_resp && last_lock && (streak < LOCK_MAX) && req[last_owner];
      if (at_resp && !cont) begin
         fav    = ~last_owner;
         streak = 0;
      end
      at_resp = 1'b0;
      if (cont) begin
         win = last_owner;
         streak++;
      end else if (req == 2'b00) begin
         next_dec = cyc + 1;
         return;
      end else begin
         win    = (req == 2'b11) ? fav : req[1];
         streak = 1;
      end
      {a, b, d, w, wd} = win ? {ra1, rb1, rd1, we[1], wdata1} : {ra0, rb0, rd0, we[0], wdata0};
      e_ra[cyc+2] = shadow[a];
      e_rb[cyc+2] = shadow[b];
`ifdef RF_ARB_R0_ZERO_EN
      if (d == '0) w = 1'b0;
      if (a == '0) e_ra[cyc+2] = '0;
      if (b == '0) e_rb[cyc+2] = '0;
`endif
      e_gnt[cyc+1] = win ? 2'b10 : 2'b01;
      e_rv[cyc+2]  = win ? 2'b10 : 2'b01;
      e_we[cyc+1]  = w;
      if (w) begin
         w_en[cyc+2]   = 1'b1;
         w_addr[cyc+2] = d;
         w_data[cyc+2] = wd;
      end
      last_owner = win;
      last_lock  = lock[win];
      at_resp    = 1'b1;
      next_dec   = cyc + 2;
      pend[win]  = 1'b0;
   endtask

   // Random requesters: a pending request stays stable until it is granted.
   task automatic drive();
      for (int i = 0; i < 2; i++) begin
         if (!pend[i]) begin
            if ($urandom_range(0, 3) != 0) begin
               pend[i] = 1'b1;
               req[i]  = 1'b1;
               lock[i] = 1'($urandom_range(0, 1));
               we[i]   = 1'($urandom_range(0, 1));
               if (i == 0) begin
                  ra0 = 4'($urandom_range(0, 15)); rb0 = 4'($urandom_range(0, 15));
                  rd0 = 4'($urandom_range(0, 15)); wdata0 = 8'($urandom);
               end else begin
                  ra1 = 4'($urandom_range(0, 15)); rb1 = 4'($urandom_range(0, 15));
                  rd1 = 4'($urandom_range(0, 15)); wdata1 = 8'($urandom);
               end
            end else begin
               req[i]  = 1'b0;
               lock[i] = 1'b0;
            end
         end
      end
   endtask

   task automatic step();
      if (auto_drv) drive();
      decide();
      @(negedge clk);
      cyc++;
      check_cycle();
   endtask

   task automatic do_reset();
      reset = 1'b0;
      req = '0; lock = '0; we = '0; pend = '0;
      model_clear(cyc + 1);
      at_resp = 1'b0; streak = 0; fav = 1'b0; last_owner = 1'b0; last_lock = 1'b0;
      next_dec = cyc + 2;
      repeat (2) begin
         @(negedge clk);
         cyc++;
         check_cycle();
      end
      reset = 1'b1;
   endtask

   initial begin
      logic [1:0] seq_q [$];
      logic [1:0] lock_exp [5];

      reset = 1'b0; mem_load = 1'b1; auto_drv = 1'b0;
      req = '0; lock = '0; we = '0; pend = '0;
      ra0 = '0; rb0 = '0; rd0 = '0; ra1 = '0; rb1 = '0; rd1 = '0;
      wdata0 = '0; wdata1 = '0;
      cyc = 0; n_cmp = 0; n_err = 0;
      for (int i = 0; i < 16; i++) shadow[i] = 8'(i * 17);
      model_clear(0);
      @(negedge clk);
      do_reset();
      mem_load = 1'b0;

      // Reset state of every output.
      chk("rst_gnt", 32'(gnt), 32'h0);
      chk("rst_rvalid", 32'(rvalid), 32'h0);
      chk("rst_rdata_a", 32'(rdata_a), 32'h0);
      chk("rst_rdata_b", 32'(rdata_b), 32'h0);
      chk("rst_rf_addr", 32'({rf_ra, rf_rb, rf_rd}), 32'h0);
      chk("rst_rf_wdata", 32'(rf_wdata), 32'h0);

      // Single read by requester 0.
      req = 2'b01; ra0 = 4'd1; rb0 = 4'd2; rd0 = 4'd0; we = 2'b00;
      step();
      chk("single_gnt", 32'(gnt), 32'h1);
      req = 2'b00;
      step();
      chk("single_rvalid", 32'(rvalid), 32'h1);
      chk("single_rdata_a", 32'(rdata_a), 32'h11);
      chk("single_rdata_b", 32'(rdata_b), 32'h22);
      step();

      // Both requesting from reset: strict alternation.
      do_reset();
      req = 2'b11; ra0 = 4'd1; rb0 = 4'd2; ra1 = 4'd3; rb1 = 4'd4;
      for (int i = 0; i < 8; i++) begin
         step();
         if (gnt != 2'b00) seq_q.push_back(gnt);
      end
      req = 2'b00;
      step(); step();
      chk("rr_count", 32'(seq_q.size()), 32'd4);
      for (int i = 0; i < 4; i++) chk("rr_order", 32'(seq_q[i]), (i % 2 == 0) ? 32'h1 : 32'h2);

      // Locked requester 1 holds LOCK_MAX grants, then requester 0 gets in.
      do_reset();
      seq_q.delete();
      lock_exp[0] = 2'b10; lock_exp[1] = 2'b10; lock_exp[2] = 2'b10;
      lock_exp[3] = 2'b10; lock_exp[4] = 2'b01;
      req = 2'b10; lock = 2'b10;
      for (int i = 0; i < 10; i++) begin
         step();
         if (gnt != 2'b00) seq_q.push_back(gnt);
         if (i == 0) req = 2'b11;
      end
      req = 2'b00; lock = 2'b00;
      step(); step();
      chk("lock_count", 32'(seq_q.size()), 32'd5);
      for (int i = 0; i < 5; i++) chk("lock_order", 32'(seq_q[i]), 32'(lock_exp[i]));

      // Write then read of r5 by requester 1.
      req = 2'b10; we = 2'b10; rd1 = 4'd5; wdata1 = 8'h3C; ra1 = 4'd5; rb1 = 4'd6;
      step();
      we = 2'b00;
      step();
      chk("raw_old_r5", 32'(rdata_a), 32'h55);
      step();
      req = 2'b00;
      step();
      chk("raw_new_r5", 32'(rdata_a), 32'h3C);
      step();

      // Write to r0 then read it back.
      req = 2'b01; we = 2'b01; rd0 = 4'd0; wdata0 = 8'hFF; ra0 = 4'd0; rb0 = 4'd1;
      step();
`ifdef RF_ARB_R0_ZERO_EN
      chk("r0_we", 32'(rf_we), 32'h0);
`else
      chk("r0_we", 32'(rf_we), 32'h1);
`endif
      we = 2'b00;
      step(); step();
      req = 2'b00;
      step();
`ifdef RF_ARB_R0_ZERO_EN
      chk("r0_read", 32'(rdata_a), 32'h00);
`else
      chk("r0_read", 32'(rdata_a), 32'hFF);
`endif
      step();

      // Reset lands in the middle of a write access: nothing may be written.
      req = 2'b01; we = 2'b01; rd0 = 4'd3; wdata0 = 8'hA5; ra0 = 4'd3;
      step();
      req = 2'b00;
      reset = 1'b0;
      #1;
      chk("midrst_gnt", 32'(gnt), 32'h0);
      chk("midrst_we", 32'(rf_we), 32'h0);
      chk("midrst_rf", 32'({rf_ra, rf_rb, rf_rd, rf_wdata}), 32'h0);
      chk("midrst_rdata", 32'({rdata_a, rdata_b}), 32'h0);
      do_reset();
      chk("midrst_r3", 32'(rf_mem[3]), 32'h33);
      step(); step();

      // Random traffic with random locks, writes and addresses.
      auto_drv = 1'b1;
      for (int i = 0; i < 1500; i++) step();
      auto_drv = 1'b0;
      req = 2'b00; lock = 2'b00;
      repeat (4) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/rf_port_arbiter.md
Name: rf_port_arbiter

Overview:
Shares the single 16x8 register file (two read ports, one write port) between two requesters. Requester 0 is the core control FSM; requester 1 is the debug/loader port. Arbitration is round-robin with an optional bounded lock, and each granted access is a fixed 3-cycle transaction. The block sits between the requesters and reg_file and owns every reg_file address, write-enable and write-data input.

Parameters:
DW, 8, register data width
AW, 4, register address width (16 registers)
LOCK_MAX, 4, max consecutive locked grants to one requester before forced rotation (1..15)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
req  in  2  per-requester request; held high until matching gnt bit seen
lock  in  2  per-requester lock: keep ownership for next access
we  in  2  per-requester write enable for the access
ra0, rb0, rd0  in  AW each  requester 0 read A / read B / write addresses
ra1, rb1, rd1  in  AW each  requester 1 addresses
wdata0, wdata1  in  DW each  write data per requester
gnt  out  2  one-hot, 1-cycle pulse: request fields captured
rvalid  out  2  one-hot, 1-cycle pulse: rdata_a/rdata_b valid for that requester
rdata_a, rdata_b  out  DW each  read results (shared bus)
rf_ra, rf_rb, rf_rd  out  AW each  to reg_file
rf_we  out  1  to reg_file write enable
rf_wdata  out  DW  to reg_file write data
rf_outa, rf_outb  in  DW each  reg_file combinational read data

Behaviour:
- Reset (reset=0, async): state IDLE; rr_ptr=0 (requester 0 favoured); lock_cnt=0; owner=0. gnt, rvalid, rf_we are 0. All address/data outputs are 0. Any in-flight access is dropped and no write occurs.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - No req: stay in IDLE.
  - Else pick winner. Single requester wins outright. Both requesting: winner = rr_ptr.
  - Register winner's ra/rb/rd/we/wdata and lock into a capture register. Set owner=winner. Go to ACCESS.
- ACCESS (cycle N+1 after req sampled at N):
  - gnt[owner]=1.
  - Drive rf_ra/rf_rb/rf_rd/rf_wdata from the capture register. rf_we = captured we, for exactly this one cycle.
  - Latch rf_outa/rf_outb into rdata_a/rdata_b. These are pre-write values; same-address read-after-write in one access returns old data.
  - Go to RESP.
- RESP (cycle N+2):
  - rvalid[owner]=1. rdata stays stable until the next RESP.
  - If captured lock=1, lock_cnt<LOCK_MAX-1 and req[owner]=1: lock_cnt++, capture owner's fields, go to ACCESS (back-to-back, other requester ignored).
  - Else: lock_cnt=0, rr_ptr=~owner, go to IDLE (or directly to ACCESS with a fresh arbitration if any req is high; arbitration is identical to IDLE).
- Throughput: one access per 2 cycles when back-to-back, 3 cycles from IDLE.
- Requesters deassert req the cycle after gnt. A req still high after its rvalid is a new request.
- lock with no pending req: lock is released, rotation proceeds.
- LOCK_MAX reached: forced rotation even if lock=1. The other requester, if requesting, wins next.
- rf_* outputs outside ACCESS: addresses hold last value, rf_we=0.

Optional Feature:
Macro RF_ARB_R0_ZERO_EN.
- Defined: r0 is hardwired zero. An access with rd=0 suppresses rf_we. rdata_a/rdata_b return 0 when the captured ra/rb=0.
- Undefined: r0 is an ordinary register.

Decomposition:
- Package rf_arb_pkg: state enum (IDLE/ACCESS/RESP), req_id_t (1-bit), capture-record struct (ra, rb, rd, we, wdata, lock), constants NUM_REQ=2, RF_AW=4, RF_DW=8.
- One sub-module, rr_pick: 2-way round-robin picker, combinational, inputs req[1:0] and rr_ptr, output winner + any.

Test Plan:
- Reset mid-ACCESS with req0, we=1, rd=3, wdata=0xA5 -> rf_we never asserts; r3 unchanged; all outputs 0; state IDLE.
- req0 alone (ra=1, rb=2, r1=0x11, r2=0x22, we=0) at cycle 0 -> gnt=01 at cycle 1, rvalid=01 at cycle 2, rdata_a=0x11, rdata_b=0x22.
- req0 and req1 both at cycle 0 after reset -> grant order 0,1,0,1 over four accesses; gnt never 11.
- req1 lock=1 held, req0 high, LOCK_MAX=4 -> four consecutive grants to 1, then requester 0 granted.
- Write then read: req1 we=1 rd=5 wdata=0x3C, ra=5 -> rdata_a=old r5; next access ra=5 -> 0x3C.
- With RF_ARB_R0_ZERO_EN: write rd=0 wdata=0xFF, then read ra=0 -> rf_we stays 0, rdata_a=0x00. Without the macro -> rdata_a=0xFF.
